// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: RV64I decode stage with 32x64 register file, immediate generation and load-use hazard detection
module instruction_decode_stage #(
  parameter int XLEN = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            stall_signal_in,
  input  logic            flush_signal_in,
  input  logic            wb_write_signal_in,
  input  logic [4:0]      wb_rd_in,
  input  logic [XLEN-1:0] wb_data_in,
  input  logic            ex_mem_read_signal_in,
  input  logic [4:0]      ex_rd_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [XLEN-1:0] imm_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [4:0]      rd_out,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic            valid_out,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic            illegal_instr_out,
`endif
  output logic            hazard_stall_out
);
  logic [XLEN-1:0] r_regs [32];
  logic [6:0]      w_op;
  logic [4:0]      w_rs1, w_rs2;
  logic            w_i, w_s, w_b, w_u, w_j, w_r;
  logic            w_bubble, w_kill;
  logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
  assign w_op  = instr_in[6:0];
  assign w_rs1 = instr_in[19:15];
  assign w_rs2 = instr_in[24:20];
  assign w_i = w_op == 7'b0010011 || w_op == 7'b0000011 || w_op == 7'b1100111 ||
               w_op == 7'b0011011 || w_op == 7'b1110011;
  assign w_s = w_op == 7'b0100011;
  assign w_b = w_op == 7'b1100011;
  assign w_u = w_op == 7'b0110111 || w_op == 7'b0010111;
  assign w_j = w_op == 7'b1101111;
  assign w_r = w_op == 7'b0110011 || w_op == 7'b0111011;
  assign w_bubble = instr_in == 32'd0 || instr_in == NOP_INSTR;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic w_illegal;
  assign w_illegal = !w_bubble && (!(w_i || w_s || w_b || w_u || w_j || w_r) || instr_in[1:0] != 2'b11);
  assign w_kill = w_bubble || w_illegal;
`else
  assign w_kill = w_bubble;
`endif
  always_comb begin
    w_imm = w_i ? {{(XLEN-12){instr_in[31]}}, instr_in[31:20]} :
            w_s ? {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]} :
            w_b ? {{(XLEN-12){instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0} :
            w_u ? {{(XLEN-32){instr_in[31]}}, instr_in[31:12], 12'd0} :
            w_j ? {{(XLEN-20){instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0} :
            '0;
  end
  // Write-through: a same-cycle writeback to the read index wins over the stored value
  assign w_rs1_data = w_rs1 == 5'd0 ? '0 :
                      (wb_write_signal_in && wb_rd_in == w_rs1) ? wb_data_in : r_regs[w_rs1];
  assign w_rs2_data = w_rs2 == 5'd0 ? '0 :
                      (wb_write_signal_in && wb_rd_in == w_rs2) ? wb_data_in : r_regs[w_rs2];
  assign hazard_stall_out = !flush_signal_in && ex_mem_read_signal_in && ex_rd_in != 5'd0 &&
                            ((!(w_u || w_j) && ex_rd_in == w_rs1) || ((w_r || w_s || w_b) && ex_rd_in == w_rs2));
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    else if (wb_write_signal_in && wb_rd_in != 5'd0)
      r_regs[wb_rd_in] <= wb_data_in;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_out       <= '0;
      rs1_data_out <= '0;
      rs2_data_out <= '0;
      imm_out      <= '0;
      rs1_out      <= '0;
      rs2_out      <= '0;
      rd_out       <= '0;
      opcode_out   <= '0;
      funct3_out   <= '0;
      funct7_out   <= '0;
      valid_out    <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_instr_out <= 1'b0;
`endif
    end else if (flush_signal_in) begin
      valid_out  <= 1'b0;
      rd_out     <= '0;
      opcode_out <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_instr_out <= 1'b0;
`endif
    end else if (!stall_signal_in) begin
      if (hazard_stall_out) begin
        // Bubble only; fetch holds so the same instruction re-decodes next cycle
        valid_out <= 1'b0;
        rd_out    <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_instr_out <= 1'b0;
`endif
      end else begin
        pc_out       <= pc_in;
        rs1_data_out <= w_rs1_data;
        rs2_data_out <= w_rs2_data;
        imm_out      <= w_imm;
        rs1_out      <= w_rs1;
        rs2_out      <= w_rs2;
        rd_out       <= w_kill ? 5'd0 : instr_in[11:7];
        opcode_out   <= w_op;
        funct3_out   <= instr_in[14:12];
        funct7_out   <= instr_in[31:25];
        valid_out    <= !w_kill;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_instr_out <= w_illegal;
`endif
      end
    end
  end
endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb_instruction_decode_stage: table-driven and directed checks of instruction_decode_stage
module tb_instruction_decode_stage;
  logic        clk, rst;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        stall, flush, wb_we, ex_ld;
  logic [4:0]  wb_rd, ex_rd;
  logic [63:0] wb_data;
  logic [63:0] pc_o, rs1_d, rs2_d, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [6:0]  op_o, f7_o;
  logic [2:0]  f3_o;
  logic        valid_o, haz_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        ill_o;
`endif
  int cnt = 0;
  int errs = 0;
  instruction_decode_stage dut (
    .clk_in(clk), .rst_in(rst), .pc_in(pc), .instr_in(instr),
    .stall_signal_in(stall), .flush_signal_in(flush),
    .wb_write_signal_in(wb_we), .wb_rd_in(wb_rd), .wb_data_in(wb_data),
    .ex_mem_read_signal_in(ex_ld), .ex_rd_in(ex_rd),
    .pc_out(pc_o), .rs1_data_out(rs1_d), .rs2_data_out(rs2_d), .imm_out(imm_o),
    .rs1_out(rs1_o), .rs2_out(rs2_o), .rd_out(rd_o), .opcode_out(op_o),
    .funct3_out(f3_o), .funct7_out(f7_o), .valid_out(valid_o),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal_instr_out(ill_o),
`endif
    .hazard_stall_out(haz_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic        valid;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic        ill;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cnt++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{32'h00528313, 64'h5,                1'b1, 5'd6,  7'h13, 1'b0};
    tbl[1]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 1'b1, 5'd29, 7'h63, 1'b0};
    tbl[2]  = '{32'h123450B7, 64'h12345000,         1'b1, 5'd1,  7'h37, 1'b0};
    tbl[3]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 1'b1, 5'd1,  7'h37, 1'b0};
    tbl[4]  = '{32'hFE20AC23, 64'hFFFFFFFFFFFFFFF8, 1'b1, 5'd24, 7'h23, 1'b0};
    tbl[5]  = '{32'h001000EF, 64'h800,              1'b1, 5'd1,  7'h6F, 1'b0};
    tbl[6]  = '{32'h00938433, 64'h0,                1'b1, 5'd8,  7'h33, 1'b0};
    tbl[7]  = '{32'h00000013, 64'h0,                1'b0, 5'd0,  7'h13, 1'b0};
    tbl[8]  = '{32'h00000000, 64'h0,                1'b0, 5'd0,  7'h00, 1'b0};
`ifdef DECODE_ILLEGAL_TRAP_EN
    tbl[9]  = '{32'h0000007F, 64'h0,                1'b0, 5'd0,  7'h7F, 1'b1};
`else
    tbl[9]  = '{32'h0000007F, 64'h0,                1'b1, 5'd0,  7'h7F, 1'b0};
`endif
    tbl[10] = '{32'hFFFFF297, 64'hFFFFFFFFFFFFF000, 1'b1, 5'd5,  7'h17, 1'b0};
    tbl[11] = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5'd1,  7'h13, 1'b0};
    rst = 0; pc = 0; instr = 0; stall = 0; flush = 0; wb_we = 0; wb_rd = 0;
    wb_data = 0; ex_ld = 0; ex_rd = 0;
    #2 rst = 1;
    #2;
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_pc", pc_o, 64'd0);
    chk("rst_imm", imm_o, 64'd0);
    chk("rst_rd", {59'd0, rd_o}, 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("rst_ill", {63'd0, ill_o}, 64'd0);
`endif
    #10 rst = 0;
    step();
    wb_we = 1; wb_rd = 5; wb_data = 64'h1234;
    step();
    wb_we = 0; instr = 32'h00528313; pc = 64'h40;
    step();
    chk("wp_rs1data", rs1_d, 64'h1234);
    chk("wp_imm", imm_o, 64'h5);
    chk("wp_rd", {59'd0, rd_o}, 64'd6);
    chk("wp_pc", pc_o, 64'h40);
    chk("wp_valid", {63'd0, valid_o}, 64'd1);
    for (int i = 0; i < 12; i++) begin
      instr = tbl[i].instr; pc = 64'h100 + 64'(i * 4);
      step();
      chk($sformatf("tbl%0d_imm", i), imm_o, tbl[i].imm);
      chk($sformatf("tbl%0d_valid", i), {63'd0, valid_o}, {63'd0, tbl[i].valid});
      chk($sformatf("tbl%0d_rd", i), {59'd0, rd_o}, {59'd0, tbl[i].rd});
      chk($sformatf("tbl%0d_op", i), {57'd0, op_o}, {57'd0, tbl[i].op});
      chk($sformatf("tbl%0d_pc", i), pc_o, 64'h100 + 64'(i * 4));
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk($sformatf("tbl%0d_ill", i), {63'd0, ill_o}, {63'd0, tbl[i].ill});
`endif
    end
    ex_ld = 1; ex_rd = 7; instr = 32'h00938433; pc = 64'h80;
    #1 chk("hz_req", {63'd0, haz_o}, 64'd1);
    step();
    chk("hz_bubble_valid", {63'd0, valid_o}, 64'd0);
    chk("hz_bubble_rd", {59'd0, rd_o}, 64'd0);
    ex_rd = 9;
    #1 chk("hz_rs2", {63'd0, haz_o}, 64'd1);
    flush = 1;
    #1 chk("hz_flush_mask", {63'd0, haz_o}, 64'd0);
    flush = 0; ex_rd = 0;
    #1 chk("hz_rd0", {63'd0, haz_o}, 64'd0);
    ex_rd = 1; instr = 32'h123450B7;
    #1 chk("hz_utype", {63'd0, haz_o}, 64'd0);
    ex_ld = 0; ex_rd = 7; instr = 32'h00938433;
    #1 chk("hz_drop", {63'd0, haz_o}, 64'd0);
    step();
    chk("hz_resume_valid", {63'd0, valid_o}, 64'd1);
    chk("hz_resume_rd", {59'd0, rd_o}, 64'd8);
    wb_we = 1; wb_rd = 3; wb_data = 64'hDEAD; instr = 32'h00018233;
    step();
    chk("byp_rs1", rs1_d, 64'hDEAD);
    chk("byp_rs2", rs2_d, 64'd0);
    wb_rd = 0; wb_data = 64'hFFFF; instr = 32'h00000233;
    step();
    chk("x0_bypass", rs1_d, 64'd0);
    wb_we = 0;
    step();
    chk("x0_stored", rs1_d, 64'd0);
    instr = 32'h00018233;
    step();
    chk("x3_stored", rs1_d, 64'hDEAD);
    instr = 32'h00528313; pc = 64'h200;
    step();
    chk("pr_load_valid", {63'd0, valid_o}, 64'd1);
    flush = 1; stall = 1; instr = 32'h123450B7; pc = 64'h300;
    step();
    chk("pr_flush_valid", {63'd0, valid_o}, 64'd0);
    chk("pr_flush_rd", {59'd0, rd_o}, 64'd0);
    chk("pr_flush_op", {57'd0, op_o}, 64'd0);
    chk("pr_flush_pc", pc_o, 64'h200);
    chk("pr_flush_imm", imm_o, 64'h5);
    flush = 0; stall = 0; instr = 32'h00938433; pc = 64'h400;
    step();
    chk("pr_add_valid", {63'd0, valid_o}, 64'd1);
    stall = 1; instr = 32'h123450B7; pc = 64'h500;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("st%0d_valid", c), {63'd0, valid_o}, 64'd1);
      chk($sformatf("st%0d_rd", c), {59'd0, rd_o}, 64'd8);
      chk($sformatf("st%0d_pc", c), pc_o, 64'h400);
      chk($sformatf("st%0d_op", c), {57'd0, op_o}, 64'h33);
    end
    #2 rst = 1;
    #1;
    chk("arst_valid", {63'd0, valid_o}, 64'd0);
    chk("arst_pc", pc_o, 64'd0);
    chk("arst_rd", {59'd0, rd_o}, 64'd0);
    chk("arst_op", {57'd0, op_o}, 64'd0);
    #2 rst = 0;
    stall = 0; instr = 32'h00528313; pc = 64'h40;
    step();
    chk("arst_rf_clear", rs1_d, 64'd0);
    chk("arst_after_valid", {63'd0, valid_o}, 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- RV64I decode stage, directly downstream of instruction fetch.
- Consumes the fetched pc/instruction pair and owns the 32x64 integer register file, including its writeback port.
- Produces registered operands, a sign-extended immediate and decoded fields for the execute stage.
- Generates the load-use hazard stall that fetch consumes on its stall input.

Parameters:
- XLEN, 64: data and pc width.
- NOP_INSTR, 32'h00000013: encoding treated as a no-op (addi x0,x0,0).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous reset, active-high.
- pc_in  input  64  pc of the fetched instruction.
- instr_in  input  32  fetched instruction word.
- stall_signal_in  input  1  external stall; hold all outputs.
- flush_signal_in  input  1  branch/interrupt redirect; kill the instruction in decode.
- wb_write_signal_in  input  1  register-file write enable.
- wb_rd_in  input  5  writeback destination.
- wb_data_in  input  64  writeback data.
- ex_mem_read_signal_in  input  1  instruction currently in EX is a load.
- ex_rd_in  input  5  destination register of the EX instruction.
- pc_out  output  64  registered pc.
- rs1_data_out  output  64  registered rs1 operand.
- rs2_data_out  output  64  registered rs2 operand.
- imm_out  output  64  registered sign-extended immediate.
- rs1_out, rs2_out, rd_out  output  5 each  registered register indices.
- opcode_out  output  7  registered opcode.
- funct3_out  output  3  registered funct3.
- funct7_out  output  7  registered funct7.
- valid_out  output  1  output bundle holds a real instruction.
- hazard_stall_out  output  1  combinational load-use stall request to fetch.

Behaviour:
- Reset (asynchronous, rst_in high):
  - All outputs go to 0.
  - All 32 register-file entries clear to 0.
  - Reset mid-operation discards the instruction in flight.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Write occurs on posedge when wb_write_signal_in=1 and wb_rd_in!=0.
- Read paths:
  - rs1/rs2 reads are combinational with write-through bypass.
  - If the same-cycle writeback targets the read index (index nonzero), the read returns wb_data_in.
- Decoded fields: opcode=instr[6:0], rd=instr[11:7], funct3=instr[14:12], rs1=instr[19:15], rs2=instr[24:20], funct7=instr[31:25].
- Immediates, sign-extended from instr[31] to 64 bits:
  - I-type: opcodes 0010011, 0000011, 1100111, 0011011, 1110011.
  - S-type: 0100011.
  - B-type: 1100011 (bit0=0).
  - U-type: 0110111, 0010111 (imm[31:12]<<12).
  - J-type: 1101111 (bit0=0).
  - R-type (0110011, 0111011) and all others: 0.
- Operand use:
  - rs2 is used only by R, S and B types.
  - rs1 is used by all formats except U and J.
- hazard_stall_out = ex_mem_read_signal_in & (ex_rd_in!=0) & ((uses_rs1 & ex_rd_in==rs1) | (uses_rs2 & ex_rd_in==rs2)). It is forced to 0 while flush_signal_in=1.
- Latency: 1 cycle from instr_in to registered outputs.
- Update priority on each posedge: reset > flush > stall > hazard > normal.
  - Flush: valid_out=0, rd_out=0, opcode_out=0, other outputs unchanged.
  - Stall (stall_signal_in=1, no flush): all outputs hold.
  - Hazard: insert a bubble (valid_out=0, rd_out=0). Fetch holds its output, so the same instruction re-decodes next cycle.
  - Normal: all outputs load; valid_out=1.
- Bubble inputs: instr_in==0 or instr_in==NOP_INSTR loads with valid_out=0 and rd_out=0.
- Simultaneous writeback and decode of a dependent instruction: the bypass supplies the new value; no stall.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port illegal_instr_out (1 bit, registered, reset 0).
  - It is set for a loaded, non-bubble instruction whose opcode is outside the supported list above, or whose instr[1:0]!=2'b11.
  - In that case valid_out=0 and rd_out=0.
  - Flush clears it; stall holds it.
- Undefined:
  - Port absent.
  - Unknown opcodes decode with imm_out=0 and valid_out=1.

Test Plan:
- Reset then write path: write x5=64'h1234 via writeback; decode instr 32'h00528313 (addi x6,x5,5) at pc 64'h40 -> next cycle rs1_data_out=64'h1234, imm_out=5, rd_out=6, pc_out=64'h40, valid_out=1.
- Negative B immediate: decode 32'hFE000EE3 (beq x0,x0,-4) -> imm_out=64'hFFFFFFFFFFFFFFFC, valid_out=1.
- Load-use hazard: ex_mem_read=1, ex_rd=7; instr add x8,x7,x9 -> hazard_stall_out=1, next valid_out=0. Drop ex_mem_read -> following cycle valid_out=1, rd_out=8.
- Write-through bypass: same cycle wb x3=64'hDEAD and decode add x4,x3,x0 -> rs1_data_out=64'hDEAD. A write to x0 is ignored: reading x0 gives 0.
- Priority: flush and stall both high with valid instr -> valid_out=0. Stall only -> outputs hold for 3 cycles. Async rst_in pulse mid-stall -> all outputs 0 immediately.
- DECODE_ILLEGAL_TRAP_EN: instr 32'h0000007F -> illegal_instr_out=1, valid_out=0. Without the macro: valid_out=1, imm_out=0.
